// File: rtl/cnn_acc_pkg.sv
// Shared definitions for the MAC accumulate/requantize stage: FSM encoding,
// saturation bound helpers and the signed-overflow check.
package cnn_acc_pkg;

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  // Bounds of a signed w-bit result, evaluated into localparams by the users.
  function automatic longint sat_max(int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Two's-complement add overflowed: operands agree in sign, sum does not.
  function automatic logic add_ovf(logic a_sign, logic b_sign, logic sum_sign);
    return (a_sign == b_sign) && (sum_sign != a_sign);
  endfunction

endpackage

// File: rtl/acc_requant.sv
// Combinational requantizer: round-half-up arithmetic right shift, optional
// ReLU clamp (RELU_EN), then saturation to a signed OUT_W result.
module acc_requant
  import cnn_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHW   = 5
) (
  input  logic signed [ACC_W-1:0] final_val,
  input  logic        [SHW-1:0]   shift,
  output logic        [OUT_W-1:0] result
);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(sat_min(OUT_W));
  localparam logic signed [ACC_W:0] ONE     = (ACC_W + 1)'(1);

  // One guard bit so the rounding increment can never wrap.
  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shd;
  logic signed [ACC_W:0] clip;

  always_comb begin
    ext = (ACC_W + 1)'(final_val);
    rnd = '0;
    if (shift != '0) rnd = ONE << (shift - SHW'(1));
    if (int'(shift) >= int'(ACC_W)) begin
      shd = ext[ACC_W] ? '1 : '0;
    end else begin
      shd = (ext + rnd) >>> shift;
    end
`ifdef RELU_EN
    clip = shd[ACC_W] ? '0 : shd;
`else
    clip = shd;
`endif
    if (clip > SAT_MAX) begin
      result = SAT_MAX[OUT_W-1:0];
    end else if (clip < SAT_MIN) begin
      result = SAT_MIN[OUT_W-1:0];
    end else begin
      result = clip[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mac_accum_stage.sv
// Window accumulator behind the shift-add multiplier: bias + LEN products,
// requantized to OUT_W with a one-cycle strobe. RELU_EN selects ReLU clamping.
module mac_accum_stage
  import cnn_acc_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN   = 25,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_synch,
  input  logic [2*DW-1:0]   prod_in,
  input  logic              prod_vld,
  input  logic [ACC_W-1:0]  bias,
  input  logic [SHW-1:0]    shift,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_vld,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [ACC_W-1:0]   acc;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   base;
  logic [ACC_W-1:0]   sum;
  logic               sum_ovf;
  logic               finalize;
  logic [OUT_W-1:0]   req;

  // The first product of a window adds onto bias instead of the accumulator.
  always_comb begin
    prod_ext = ACC_W'($signed(prod_in));
    base     = (state == ST_IDLE) ? bias : acc;
    sum      = base + prod_ext;
    sum_ovf  = add_ovf(base[ACC_W-1], prod_ext[ACC_W-1], sum[ACC_W-1]);
    if (state == ST_ACC) finalize = prod_vld && (cnt == CW'(LEN - 1));
    else                 finalize = prod_vld && (LEN == 1);
  end

  acc_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHW   (SHW)
  ) u_requant (
    .final_val (sum),
    .shift     (shift),
    .result    (req)
  );

  always_ff @(posedge clk) begin
    if (rst || !en_synch) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      if (prod_vld) begin
        ovf <= ovf | sum_ovf;
        if (finalize) begin
          out_data <= req;
          out_vld  <= 1'b1;
          state    <= ST_IDLE;
          cnt      <= '0;
        end else begin
          acc   <= sum;
          cnt   <= cnt + CW'(1);
          state <= ST_ACC;
        end
      end
    end
  end

  assign busy = (state == ST_ACC);

endmodule

// File: tb/tb_mac_accum_stage.sv
// Directed bench for mac_accum_stage with LEN=4: a 24-bit accumulator instance
// and a 16-bit one sharing stimulus for the overflow scenario.
module tb_mac_accum_stage;

`ifdef RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en_synch = 1'b1;
  logic signed [15:0] prod_in = '0;
  logic               prod_vld = 1'b0;
  logic signed [23:0] bias = '0;
  logic [4:0]         shift = 5'd2;

  logic [7:0] out_data, out_data16;
  logic       out_vld, out_vld16, busy, busy16, ovf, ovf16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_accum_stage #(.DW(8), .ACC_W(24), .LEN(4), .OUT_W(8), .SHW(5)) dut (
    .clk(clk), .rst(rst), .en_synch(en_synch), .prod_in(prod_in), .prod_vld(prod_vld),
    .bias(bias), .shift(shift), .out_data(out_data), .out_vld(out_vld), .busy(busy),
    .ovf(ovf)
  );

  mac_accum_stage #(.DW(8), .ACC_W(16), .LEN(4), .OUT_W(8), .SHW(5)) dut16 (
    .clk(clk), .rst(rst), .en_synch(en_synch), .prod_in(prod_in), .prod_vld(prod_vld),
    .bias(bias[15:0]), .shift(shift), .out_data(out_data16), .out_vld(out_vld16),
    .busy(busy16), .ovf(ovf16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    prod_in  = 16'(v);
    prod_vld = 1'b1;
    step();
    prod_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks += 4;
    if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", out_data); end
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", out_vld); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_basic();
    int p[4] = '{10, 20, 30, 40};
    bias  = '0;
    shift = 5'd2;
    for (int i = 0; i < 4; i++) begin
      send(p[i]);
      n_checks++;
      if (busy !== (i < 3)) begin
        n_fail++; $display("FAIL basic_busy[%0d] got %b want %b", i, busy, (i < 3));
      end
    end
    n_checks += 2;
    if (out_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld got %b want 1", out_vld); end
    if (out_data !== 8'd25) begin
      n_fail++; $display("FAIL basic_data got %0d want 25", $signed(out_data));
    end
    step();
    n_checks += 2;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got %b want 0", out_vld); end
    if (out_data !== 8'd25) begin
      n_fail++; $display("FAIL basic_hold got %0d want 25", $signed(out_data));
    end
  endtask

  task automatic test_neg_bias();
    logic [7:0] want;
    want  = RELU ? 8'd0 : 8'(-3);
    bias  = -24'sd2;
    shift = 5'd2;
    send(-3);
    bias = 24'sd100;  // must not disturb the window already in progress
    send(-3);
    send(-3);
    send(-3);
    n_checks += 2;
    if (out_vld !== 1'b1) begin n_fail++; $display("FAIL negbias_vld got %b want 1", out_vld); end
    if (out_data !== want) begin
      n_fail++; $display("FAIL negbias_data got %0d want %0d", $signed(out_data), $signed(want));
    end
    bias = '0;
  endtask

  task automatic test_saturation();
    logic [7:0] want_neg;
    want_neg = RELU ? 8'd0 : 8'h80;
    shift = 5'd2;
    for (int i = 0; i < 4; i++) send(16129);
    n_checks += 3;
    if (out_vld !== 1'b1) begin n_fail++; $display("FAIL satpos_vld got %b want 1", out_vld); end
    if (out_data !== 8'd127) begin
      n_fail++; $display("FAIL satpos_data got %0d want 127", $signed(out_data));
    end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL satpos_ovf got %b want 0", ovf); end
    for (int i = 0; i < 4; i++) send(-16256);
    n_checks++;
    if (out_data !== want_neg) begin
      n_fail++;
      $display("FAIL satneg_data got %0d want %0d", $signed(out_data), $signed(want_neg));
    end
  endtask

  task automatic test_throughput();
    int got[2];
    int k;
    shift = 5'd0;
    bias  = '0;
    for (int i = 1; i <= 8; i++) begin
      send(i);
      n_checks++;
      if (out_vld !== (i == 4 || i == 8)) begin
        n_fail++; $display("FAIL b2b_vld[%0d] got %b want %b", i, out_vld, (i == 4 || i == 8));
      end
      if (i == 4) got[0] = int'($signed(out_data));
      if (i == 8) got[1] = int'($signed(out_data));
    end
    n_checks += 2;
    if (got[0] !== 10) begin n_fail++; $display("FAIL b2b_win0 got %0d want 10", got[0]); end
    if (got[1] !== 26) begin n_fail++; $display("FAIL b2b_win1 got %0d want 26", got[1]); end
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      send(i);
      if (out_vld === 1'b1) begin
        if (k < 2) got[k] = int'($signed(out_data));
        k++;
      end
      repeat ($urandom_range(0, 3)) begin
        step();
        n_checks++;
        if (out_vld !== 1'b0) begin n_fail++; $display("FAIL gap_vld got %b want 0", out_vld); end
      end
    end
    n_checks += 3;
    if (k !== 2) begin n_fail++; $display("FAIL gap_count got %0d want 2", k); end
    if (got[0] !== 10) begin n_fail++; $display("FAIL gap_win0 got %0d want 10", got[0]); end
    if (got[1] !== 26) begin n_fail++; $display("FAIL gap_win1 got %0d want 26", got[1]); end
  endtask

  // use_rst=0 clears with en_synch, 1 with rst; the clear lands on what would
  // otherwise be the finalizing product.
  task automatic test_clear(input bit use_rst);
    shift = 5'd2;
    bias  = '0;
    send(50);
    send(60);
    send(70);
    if (use_rst) rst = 1'b1;
    else         en_synch = 1'b0;
    send(80);
    rst      = 1'b0;
    en_synch = 1'b1;
    n_checks += 2;
    if (out_vld !== 1'b0) begin
      n_fail++; $display("FAIL clear%0d_vld got %b want 0", use_rst, out_vld);
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL clear%0d_busy got %b want 0", use_rst, busy);
    end
    for (int i = 0; i < 4; i++) send(1);
    n_checks += 2;
    if (out_vld !== 1'b1) begin
      n_fail++; $display("FAIL clear%0d_post_vld got %b want 1", use_rst, out_vld);
    end
    if (out_data !== 8'd1) begin
      n_fail++; $display("FAIL clear%0d_post_data got %0d want 1", use_rst, $signed(out_data));
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want16;
    // 4*16129 wraps in 16 bits to -1020, which saturates low.
    want16 = RELU ? 8'd0 : 8'h80;
    rst = 1'b1;
    step();
    rst   = 1'b0;
    shift = 5'd0;
    bias  = '0;
    for (int i = 0; i < 4; i++) send(16129);
    n_checks += 5;
    if (ovf16 !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf16); end
    if (out_vld16 !== 1'b1) begin n_fail++; $display("FAIL ovf_vld got %b want 1", out_vld16); end
    if (out_data16 !== want16) begin
      n_fail++; $display("FAIL ovf_data got %0d want %0d", $signed(out_data16), $signed(want16));
    end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_wide got %b want 0", ovf); end
    if (out_data !== 8'd127) begin
      n_fail++; $display("FAIL ovf_wide_data got %0d want 127", $signed(out_data));
    end
    for (int i = 0; i < 4; i++) send(1);
    n_checks += 2;
    if (ovf16 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf16); end
    if (out_data16 !== 8'd4) begin
      n_fail++; $display("FAIL ovf_next_data got %0d want 4", $signed(out_data16));
    end
    en_synch = 1'b0;
    step();
    en_synch = 1'b1;
    n_checks += 2;
    if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", ovf16); end
    if (out_data16 !== 8'd0) begin
      n_fail++; $display("FAIL ovf_clear_data got %0d want 0", $signed(out_data16));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_bias();
    test_saturation();
    test_throughput();
    test_clear(1'b0);
    test_clear(1'b1);
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accum_stage.md
Name: mac_accum_stage

Overview:
- Downstream consumer of the pipelined signed shift-add multiplier in each systolic PE column.
- Accumulates a fixed-length window of signed products (one conv kernel window), adds a per-channel bias, then requantizes with rounding shift and saturation.
- Emits one OUT_W result per window with a single-cycle valid pulse, feeding the activation/line-buffer writeback.

Parameters:
- DW, 8, multiplier operand width; the product input is 2*DW wide.
- ACC_W, 24, accumulator width; must be at least 2*DW.
- LEN, 25, products per window (5x5 kernel); must be at least 1.
- OUT_W, 8, signed output width.
- SHW, 5, width of the shift-amount port.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en_synch  in  1  active-low synchronous clear, same meaning as the multiplier's en_synch.
- prod_in  in  2*DW  signed product (multiplier mul_result).
- prod_vld  in  1  product valid (multiplier result_flag).
- bias  in  ACC_W  signed bias, sampled on the first product of each window.
- shift  in  SHW  requantize right-shift amount, static per layer.
- out_data  out  OUT_W  signed requantized result.
- out_vld  out  1  one-cycle result strobe.
- busy  out  1  high while a window is partially accumulated.
- ovf  out  1  sticky accumulator signed-overflow flag.

Behaviour:
- Reset (rst=1) or en_synch=0 at a clock edge:
  - out_data=0, out_vld=0, busy=0, ovf=0.
  - Counter=0, accumulator=0, FSM=IDLE.
  - rst takes precedence over all other inputs.
  - An en_synch clear also discards any partial window and suppresses out_vld for that cycle.
- FSM states IDLE and ACC; count cnt runs 0..LEN-1.
  - IDLE with prod_vld: acc <= bias + sext(prod_in); cnt <= 1; go to ACC. If LEN==1, finalize instead and stay in IDLE.
  - ACC with prod_vld and cnt<LEN-1: acc <= acc + sext(prod_in); cnt++.
  - ACC with prod_vld and cnt==LEN-1: finalize; cnt <= 0; go to IDLE.
  - Without prod_vld, state, acc and cnt hold. Gaps of any length are legal.
- Finalize:
  - final = acc + sext(prod_in), computed combinationally.
  - Requantize: r = (final + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, arithmetic shift, round half up.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the result into out_data and pulse out_vld=1 on the next edge.
- Latency: out_vld is high in the cycle after the edge that accepts the LEN-th product.
- out_data holds its value until the next finalize. out_vld is 0 in all other cycles.
- Back-to-back windows need no bubble. A product arriving in the cycle after finalize is accepted from IDLE as the first product of the next window. Sustained throughput is one product per cycle.
- busy = (state==ACC).
- ovf: set when an addition in acc or final overflows ACC_W as signed (operands of equal sign, sum of opposite sign). The sum wraps modulo 2^ACC_W. ovf clears only on rst or en_synch=0.
- shift values of ACC_W or more produce 0 or -1 according to sign, with no X propagation.
- bias and shift changes mid-window do not affect that window's bias; bias is captured only on the first product.

Optional Feature:
- Macro RELU_EN.
- Defined: after rounding and before saturation, negative r is clamped to 0, so out_data is never negative.
- Undefined: signed passthrough with symmetric saturation only.
- Port list is identical either way.

Decomposition:
- Package cnn_acc_pkg holds:
  - state encoding (ST_IDLE, ST_ACC);
  - localparams for the saturation bounds SAT_MAX/SAT_MIN as functions of OUT_W;
  - a function for the signed-overflow check.
- One sub-module: acc_requant. It is purely combinational: round, shift, optional ReLU and saturate, taking final and shift and producing OUT_W.
- The FSM, counter and registers stay in mac_accum_stage.

Test Plan:
- Basic window (LEN=4, SHIFT=2, bias=0): products 10,20,30,40 on consecutive cycles -> sum 100, out_data=25, out_vld exactly one cycle after the 4th product; busy high for cycles 1..3.
- Negative with bias (LEN=4, shift=2, bias=-2): products -3,-3,-3,-3 -> final=-14, out_data=-3 (with RELU_EN: 0).
- Saturation (LEN=4, shift=2, bias=0): four products of 16129 (127*127) -> r=16129, out_data=127, ovf=0. Four products of -16256 (-128*127) -> out_data=-128.
- Throughput and gaps: 8 consecutive valids -> out_vld pulses at cycles 5 and 9. The same 8 products with random 0-3 cycle gaps -> identical out_data values.
- Clear and reset mid-window: 2 products, then en_synch=0 for one cycle, then products 1,1,1,1 -> out_data=1 (shift=2: 4>>2=1), with no out_vld during the clear. Repeat using rst=1 -> same result.
- Overflow (ACC_W=16, LEN=4, shift=0): four products of 16129 -> ovf=1, which stays set through the next window until rst or en_synch=0; out_data equals the saturated value of the wrapped sum.
